// File: rtl/sdram_arbit_rr.sv
// SDRAM command arbiter: multiplexes init, auto-refresh and NUM_CH round-robin
// access channels onto one SDRAM command/data bus, with a per-operation watchdog.
module sdram_arbit_rr #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 13,
    parameter int BA_W    = 2,
    parameter int DQ_W    = 16,
    parameter int TMO_CYC = 1024
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,

    input  logic                     init_end_i,
    input  logic [3:0]               init_cmd_i,
    input  logic [BA_W-1:0]          init_ba_i,
    input  logic [ADDR_W-1:0]        init_addr_i,

    input  logic                     aref_req_i,
    input  logic                     aref_end_i,
    input  logic [3:0]               aref_cmd_i,
    input  logic [BA_W-1:0]          aref_ba_i,
    input  logic [ADDR_W-1:0]        aref_addr_i,
    output logic                     aref_en_o,

    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH-1:0]        ch_end_i,
    input  logic [4*NUM_CH-1:0]      ch_cmd_i,
    input  logic [BA_W*NUM_CH-1:0]   ch_ba_i,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr_i,
    input  logic [DQ_W*NUM_CH-1:0]   ch_wr_data_i,
    input  logic [NUM_CH-1:0]        ch_dq_oe_i,

    output logic [NUM_CH-1:0]        ch_gnt_o,
    output logic [DQ_W-1:0]          rd_data_o,
    output logic                     tmo_err_o,

    output logic                     sdram_cke_o,
    output logic                     sdram_cs_n_o,
    output logic                     sdram_ras_n_o,
    output logic                     sdram_cas_n_o,
    output logic                     sdram_we_n_o,
    output logic [BA_W-1:0]          sdram_ba_o,
    output logic [ADDR_W-1:0]        sdram_addr_o,
    inout  wire  [DQ_W-1:0]          sdram_dq_io
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W  = $clog2(TMO_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARBIT  = 2'd1,
        AREF   = 2'd2,
        ACCESS = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                aref_en_q, aref_en_d;
    logic                tmo_q, tmo_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [DQ_W-1:0]     wdata_q;
    logic [DQ_W-1:0]     rdata_q;

    logic [PTR_W-1:0]    gidx;
    logic [PTR_W-1:0]    win, hi_win;
    logic                win_vld, hi_vld;
    logic [3:0]          sel_cmd;
    logic [BA_W-1:0]     sel_ba;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DQ_W-1:0]     sel_wdata;
    logic                sel_oe;
    logic                sel_end;
    logic                wd_hit;
    logic [3:0]          cmd;

    // Round-robin: lowest requester above ptr, else wrap to lowest requester overall.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        hi_win  = '0;
        hi_vld  = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_req_i[k]) begin
                win     = PTR_W'(k);
                win_vld = 1'b1;
            end
            if (ch_req_i[k] && (k > int'(ptr_q))) begin
                hi_win = PTR_W'(k);
                hi_vld = 1'b1;
            end
        end
        if (hi_vld) begin
            win = hi_win;
        end
    end

    always_comb begin
        gidx      = '0;
        sel_cmd   = '0;
        sel_ba    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_oe    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_q[k]) begin
                gidx      = PTR_W'(k);
                sel_cmd   = ch_cmd_i[k*4 +: 4];
                sel_ba    = ch_ba_i[k*BA_W +: BA_W];
                sel_addr  = ch_addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = ch_wr_data_i[k*DQ_W +: DQ_W];
                sel_oe    = ch_dq_oe_i[k];
            end
        end
    end

    // Only the granted channel's end strobe is honoured.
    assign sel_end = |(ch_end_i & gnt_q);
    assign wd_hit  = (wdog_q == WD_W'(TMO_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= PTR_W'(NUM_CH - 1);
            aref_en_q <= 1'b0;
            tmo_q     <= 1'b0;
            wdog_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            aref_en_q <= aref_en_d;
            tmo_q     <= tmo_d;
            wdog_q    <= wdog_d;
            wdata_q   <= sel_wdata;
            rdata_q   <= sdram_dq_io;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        aref_en_d = aref_en_q;
        tmo_d     = 1'b0;
        wdog_d    = '0;
        case (state_q)
            IDLE: begin
                if (init_end_i) begin
                    state_d = ARBIT;
                end
            end
            ARBIT: begin
                if (aref_req_i) begin
                    state_d   = AREF;
                    aref_en_d = 1'b1;
                end else if (win_vld) begin
                    state_d = ACCESS;
                    for (int k = 0; k < NUM_CH; k++) begin
                        gnt_d[k] = (win == PTR_W'(k));
                    end
                end
            end
            AREF: begin
                if (aref_end_i || wd_hit) begin
                    state_d   = ARBIT;
                    aref_en_d = 1'b0;
                    tmo_d     = !aref_end_i;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ACCESS: begin
                // A stalled channel is retired like a finished one so the pointer moves past it.
                if (sel_end || wd_hit) begin
                    state_d = ARBIT;
                    gnt_d   = '0;
                    ptr_d   = gidx;
                    tmo_d   = !sel_end;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd          = init_cmd_i;
        sdram_ba_o   = init_ba_i;
        sdram_addr_o = init_addr_i;
        case (state_q)
            ARBIT: begin
                cmd          = 4'b0111;
                sdram_ba_o   = '1;
                sdram_addr_o = '1;
            end
            AREF: begin
                cmd          = aref_cmd_i;
                sdram_ba_o   = aref_ba_i;
                sdram_addr_o = aref_addr_i;
            end
            ACCESS: begin
                cmd          = sel_cmd;
                sdram_ba_o   = sel_ba;
                sdram_addr_o = sel_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} = cmd;
    assign sdram_cke_o = 1'b1;

    assign sdram_dq_io = ((state_q == ACCESS) && sel_oe) ? wdata_q : {DQ_W{1'bz}};

    assign ch_gnt_o  = gnt_q;
    assign aref_en_o = aref_en_q;
    assign tmo_err_o = tmo_q;
    assign rd_data_o = rdata_q;

endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Directed bench for sdram_arbit_rr: arbitration order, refresh priority,
// watchdog, data path and reset behaviour with hand-derived expectations.
module tb_sdram_arbit_rr;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 16;
    localparam int TMO    = 16;

    localparam logic [3:0] INIT_CMD = 4'b0010;
    localparam logic [3:0] AREF_CMD = 4'b0001;
    localparam logic [3:0] NOP_CMD  = 4'b0111;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst_n;
    logic                     init_end_i;
    logic [3:0]               init_cmd_i;
    logic [BA_W-1:0]          init_ba_i;
    logic [ADDR_W-1:0]        init_addr_i;
    logic                     aref_req_i, aref_end_i;
    logic [3:0]               aref_cmd_i;
    logic [BA_W-1:0]          aref_ba_i;
    logic [ADDR_W-1:0]        aref_addr_i;
    logic                     aref_en_o;
    logic [NUM_CH-1:0]        ch_req_i, ch_end_i, ch_dq_oe_i;
    logic [4*NUM_CH-1:0]      ch_cmd_i;
    logic [BA_W*NUM_CH-1:0]   ch_ba_i;
    logic [ADDR_W*NUM_CH-1:0] ch_addr_i;
    logic [DQ_W*NUM_CH-1:0]   ch_wr_data_i;
    logic [NUM_CH-1:0]        ch_gnt_o;
    logic [DQ_W-1:0]          rd_data_o;
    logic                     tmo_err_o;
    logic                     cke, cs_n, ras_n, cas_n, we_n;
    logic [BA_W-1:0]          ba_o;
    logic [ADDR_W-1:0]        addr_o;
    wire  [DQ_W-1:0]          dq;
    logic                     tb_drv;
    logic [DQ_W-1:0]          tb_val;

    int n_cmp = 0;
    int n_err = 0;

    assign dq = tb_drv ? tb_val : {DQ_W{1'bz}};

    always #5 sys_clk = ~sys_clk;

    sdram_arbit_rr #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W), .TMO_CYC(TMO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .init_end_i(init_end_i), .init_cmd_i(init_cmd_i), .init_ba_i(init_ba_i),
        .init_addr_i(init_addr_i),
        .aref_req_i(aref_req_i), .aref_end_i(aref_end_i), .aref_cmd_i(aref_cmd_i),
        .aref_ba_i(aref_ba_i), .aref_addr_i(aref_addr_i), .aref_en_o(aref_en_o),
        .ch_req_i(ch_req_i), .ch_end_i(ch_end_i), .ch_cmd_i(ch_cmd_i), .ch_ba_i(ch_ba_i),
        .ch_addr_i(ch_addr_i), .ch_wr_data_i(ch_wr_data_i), .ch_dq_oe_i(ch_dq_oe_i),
        .ch_gnt_o(ch_gnt_o), .rd_data_o(rd_data_o), .tmo_err_o(tmo_err_o),
        .sdram_cke_o(cke), .sdram_cs_n_o(cs_n), .sdram_ras_n_o(ras_n),
        .sdram_cas_n_o(cas_n), .sdram_we_n_o(we_n), .sdram_ba_o(ba_o),
        .sdram_addr_o(addr_o), .sdram_dq_io(dq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [3:0] cmd_now();
        return {cs_n, ras_n, cas_n, we_n};
    endfunction

    initial begin
        logic [3:0] exp_g;

        sys_rst_n    = 1'b0;
        init_end_i   = 1'b0;
        init_cmd_i   = INIT_CMD;
        init_ba_i    = 2'b01;
        init_addr_i  = 13'h00AA;
        aref_req_i   = 1'b0;
        aref_end_i   = 1'b0;
        aref_cmd_i   = AREF_CMD;
        aref_ba_i    = 2'b10;
        aref_addr_i  = 13'h0400;
        ch_req_i     = '0;
        ch_end_i     = '0;
        ch_dq_oe_i   = '0;
        ch_cmd_i     = {4'b1011, 4'b1010, 4'b1001, 4'b1000};
        ch_ba_i      = {2'd3, 2'd2, 2'd1, 2'd0};
        ch_addr_i    = {13'h0303, 13'h0202, 13'h0101, 13'h0000};
        ch_wr_data_i = '0;
        tb_drv       = 1'b0;
        tb_val       = '0;

        // Reset state
        #12;
        chk("rst_gnt", 32'(ch_gnt_o), 0);
        chk("rst_aref_en", 32'(aref_en_o), 0);
        chk("rst_tmo", 32'(tmo_err_o), 0);
        chk("rst_rd", 32'(rd_data_o), 0);
        chk("rst_cmd", 32'(cmd_now()), 32'(INIT_CMD));
        chk("rst_ba", 32'(ba_o), 1);
        chk("rst_addr", 32'(addr_o), 32'h00AA);
        chk("rst_cke", 32'(cke), 1);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        tick();
        chk("idle_cmd", 32'(cmd_now()), 32'(INIT_CMD));

        // Refresh beats all channels after init
        aref_req_i = 1'b1;
        ch_req_i   = 4'b1111;
        init_end_i = 1'b1;
        tick();
        chk("arb_cmd", 32'(cmd_now()), 32'(NOP_CMD));
        chk("arb_ba", 32'(ba_o), 3);
        chk("arb_addr", 32'(addr_o), 32'h1FFF);
        chk("arb_aref_en", 32'(aref_en_o), 0);
        tick();
        chk("aref_cmd", 32'(cmd_now()), 32'(AREF_CMD));
        chk("aref_ba", 32'(ba_o), 2);
        chk("aref_en", 32'(aref_en_o), 1);
        chk("aref_gnt", 32'(ch_gnt_o), 0);
        aref_req_i = 1'b0;
        tick();
        chk("aref_hold_gnt", 32'(ch_gnt_o), 0);
        chk("aref_hold_en", 32'(aref_en_o), 1);
        aref_end_i = 1'b1;
        tick();
        aref_end_i = 1'b0;
        chk("aref_done_cmd", 32'(cmd_now()), 32'(NOP_CMD));
        chk("aref_done_en", 32'(aref_en_o), 0);
        chk("aref_done_gnt", 32'(ch_gnt_o), 0);

        // Round-robin rotation with all channels requesting, 3-cycle accesses
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            chk("rr_gnt_c1", 32'(ch_gnt_o), 32'(exp_g));
            chk("rr_cmd", 32'(cmd_now()), 32'(4'b1000 | 4'(k % 4)));
            ch_end_i = ~exp_g;
            tick();
            ch_end_i = '0;
            chk("rr_gnt_c2", 32'(ch_gnt_o), 32'(exp_g));
            tick();
            chk("rr_gnt_c3", 32'(ch_gnt_o), 32'(exp_g));
            ch_end_i = exp_g;
            tick();
            ch_end_i = '0;
            chk("rr_gap_gnt", 32'(ch_gnt_o), 0);
            chk("rr_gap_cmd", 32'(cmd_now()), 32'(NOP_CMD));
        end

        // ptr=0, requests 0101 -> channel 2; refresh waits for access end
        ch_req_i = 4'b0101;
        tick();
        chk("rr5_gnt", 32'(ch_gnt_o), 32'h4);
        chk("rr5_ba", 32'(ba_o), 2);
        chk("rr5_addr", 32'(addr_o), 32'h0202);
        aref_req_i = 1'b1;
        tick();
        chk("nopre_gnt", 32'(ch_gnt_o), 32'h4);
        chk("nopre_cmd", 32'(cmd_now()), 32'(4'b1010));
        chk("nopre_aref_en", 32'(aref_en_o), 0);
        ch_end_i = 4'b0100;
        tick();
        ch_end_i = '0;
        chk("nopre_end_gnt", 32'(ch_gnt_o), 0);
        chk("nopre_end_cmd", 32'(cmd_now()), 32'(NOP_CMD));
        tick();
        chk("post_aref_cmd", 32'(cmd_now()), 32'(AREF_CMD));
        chk("post_aref_en", 32'(aref_en_o), 1);
        aref_req_i = 1'b0;
        aref_end_i = 1'b1;
        tick();
        aref_end_i = 1'b0;
        chk("post_aref_done", 32'(aref_en_o), 0);

        // Data path: ptr=2, requests 0101 -> channel 0
        tick();
        chk("dq_gnt", 32'(ch_gnt_o), 32'h1);
        ch_wr_data_i[15:0] = 16'hA5A5;
        ch_wr_data_i[47:32] = 16'h5A5A;
        ch_dq_oe_i = 4'b0101;
        tick();
        chk("dq_wr", 32'(dq), 32'hA5A5);
        tick();
        chk("dq_rd_own", 32'(rd_data_o), 32'hA5A5);
        ch_dq_oe_i = 4'b0100;
        tb_drv = 1'b1;
        tb_val = 16'h1234;
        #1;
        chk("dq_ext", 32'(dq), 32'h1234);
        tick();
        chk("dq_rd_ext", 32'(rd_data_o), 32'h1234);
        tb_drv = 1'b0;
        ch_dq_oe_i = '0;
        ch_end_i = 4'b0001;
        tick();
        ch_end_i = '0;
        chk("dq_end_gnt", 32'(ch_gnt_o), 0);

        // Watchdog: ptr=0 -> channel 2 stalls for 16 cycles
        tick();
        chk("wd_gnt", 32'(ch_gnt_o), 32'h4);
        for (int c = 2; c <= TMO; c++) begin
            chk("wd_busy_tmo", 32'(tmo_err_o), 0);
            tick();
        end
        chk("wd_c16_gnt", 32'(ch_gnt_o), 32'h4);
        chk("wd_c16_tmo", 32'(tmo_err_o), 0);
        tick();
        chk("wd_pulse", 32'(tmo_err_o), 1);
        chk("wd_gnt_clr", 32'(ch_gnt_o), 0);
        chk("wd_cmd", 32'(cmd_now()), 32'(NOP_CMD));
        tick();
        chk("wd_pulse_end", 32'(tmo_err_o), 0);
        chk("wd_next_gnt", 32'(ch_gnt_o), 32'h1);

        // End coincides with timeout: normal end, no error pulse
        for (int c = 2; c <= TMO; c++) begin
            tick();
        end
        chk("wdend_gnt", 32'(ch_gnt_o), 32'h1);
        ch_end_i = 4'b0001;
        tick();
        ch_end_i = '0;
        chk("wdend_tmo", 32'(tmo_err_o), 0);
        chk("wdend_gnt_clr", 32'(ch_gnt_o), 0);

        // Single requester is re-granted after one NOP cycle
        ch_req_i = 4'b0010;
        tick();
        chk("single_gnt1", 32'(ch_gnt_o), 32'h2);
        ch_end_i = 4'b0010;
        tick();
        ch_end_i = '0;
        chk("single_gap", 32'(ch_gnt_o), 0);
        tick();
        chk("single_gnt2", 32'(ch_gnt_o), 32'h2);

        // Asynchronous reset in the middle of an access
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mrst_gnt", 32'(ch_gnt_o), 0);
        chk("mrst_aref_en", 32'(aref_en_o), 0);
        chk("mrst_tmo", 32'(tmo_err_o), 0);
        chk("mrst_rd", 32'(rd_data_o), 0);
        chk("mrst_cmd", 32'(cmd_now()), 32'(INIT_CMD));
        init_end_i = 1'b0;
        ch_req_i = '0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        tick();
        chk("mrst_idle_cmd", 32'(cmd_now()), 32'(INIT_CMD));
        init_end_i = 1'b1;
        tick();
        chk("mrst_arb_cmd", 32'(cmd_now()), 32'(NOP_CMD));
        ch_req_i = 4'b1001;
        tick();
        chk("mrst_ptr_gnt", 32'(ch_gnt_o), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
